nibble_word_assembler: RTL and testbench
========================================

NIBBLE_WORD_ASSEMBLER -- requirements
Module: nibble_word_assembler

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request to begin assembling a new word; honoured only as defined in REQ-015/REQ-021.
REQ-005 reverse_direction  input  1  sampled with an accepted start; 0 = LSB nibble first (index 0..7), 1 = MSB nibble first (index 7..0).
REQ-006 abort  input  1  discards a partially assembled word.
REQ-007 nib_valid  input  1  nib_data is valid this cycle.
REQ-008 nib_data  input  4  incoming nibble.
REQ-009 nib_ready  output  1  block accepts a nibble this cycle.
REQ-010 word_valid  output  1  word holds a complete assembled word.
REQ-011 word_ready  input  1  consumer takes the word this cycle.
REQ-012 word  output  32  assembled word.
REQ-013 busy  output  1  high in COLLECT and HOLD states.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, COLLECT, HOLD.
REQ-015 In IDLE, start=1 SHALL move to COLLECT next cycle, clear the accumulator to 0, latch reverse_direction, and load the nibble index with 0 (forward) or 7 (reverse).
REQ-016 nib_ready SHALL equal (state==COLLECT) && !abort, combinationally.
REQ-017 A nibble transfer SHALL occur when nib_valid && nib_ready at a rising clk; nib_data SHALL be written to accumulator bits [idx*4+3:idx*4], all other bits unchanged.
REQ-018 After each transfer idx SHALL increment (forward) or decrement (reverse) by 1; idx is 3 bits, and the eighth transfer ends the word, so idx never wraps within a word.
REQ-019 On the eighth transfer the FSM SHALL enter HOLD; word_valid SHALL rise the cycle after that transfer (one-cycle latency), with word equal to the complete accumulator.
REQ-020 In HOLD, word and word_valid SHALL remain stable until word_ready=1; nib_ready SHALL be 0.
REQ-021 In HOLD with word_ready=1: start=0 -> IDLE; start=1 -> COLLECT directly (back-to-back), applying the REQ-015 initialisation.
REQ-022 In COLLECT, abort=1 SHALL return to IDLE next cycle; a nibble presented in the same cycle SHALL NOT be transferred; word_valid stays 0.
REQ-023 abort SHALL be ignored in IDLE and HOLD; start SHALL be ignored in COLLECT and in HOLD without word_ready.
REQ-024 nib_valid with nib_ready=0 SHALL have no effect (no data capture, no index change).
REQ-025 word_valid SHALL be high exactly when state==HOLD; busy SHALL be high exactly when state!=IDLE.
REQ-026 word SHALL always reflect the accumulator; it is only guaranteed meaningful while word_valid=1.

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE, accumulator/word=0, idx=0, latched direction=0, word_valid=0, busy=0, nib_ready=0, independent of clk.
REQ-028 Reset asserted mid-COLLECT or mid-HOLD SHALL discard the word; after release, the block SHALL wait in IDLE for start.

Configuration
REQ-029 Macro WORD_PARITY_EN SHALL, when defined, add output word_parity (1 bit) = XOR-reduction of word, registered and updated on entry to HOLD, reset value 0, valid while word_valid=1.
REQ-030 Without WORD_PARITY_EN the word_parity port and its logic SHALL NOT exist; all other behaviour is identical.

Verification
REQ-031 Forward: start, rev=0, nibbles F,F,F,F,0,0,0,F with nib_valid=1 every cycle, word_ready=1 -> word_valid one cycle after 8th transfer, word=32'hF000_FFFF, held one cycle, then IDLE.
REQ-032 Reverse: start, rev=1, nibbles 1,2,3,4,5,6,7,8 -> word=32'h1234_5678; with WORD_PARITY_EN, word_parity=1.
REQ-033 Backpressure: nib_valid toggled 1,0,1,0..., word_ready held 0 for 5 cycles -> only valid cycles captured, word stable for all 5 HOLD cycles, nib_ready=0 throughout HOLD.
REQ-034 Abort: after 3 nibbles, abort=1 with nib_valid=1 -> IDLE next cycle, busy=0, no word_valid; a new start then yields the correct new word, with no residue from the aborted one.
REQ-035 Back-to-back: word_ready=1 and start=1 in the same HOLD cycle -> COLLECT next cycle, second word assembled correctly and word_valid never asserted spuriously.
REQ-036 Reset mid-COLLECT after 5 nibbles -> all outputs 0 at once; after release, nib_ready=0 until start.

Source files
------------

// File: rtl/nibble_word_assembler.sv
// Packs eight 4-bit nibbles (LSB- or MSB-first) into a 32-bit word; word_valid rises one cycle after the 8th transfer.
// The word is held until word_ready, with nib_ready low meanwhile. Optional WORD_PARITY_EN adds a registered word_parity.
module nibble_word_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        reverse_direction,
    input  logic        abort,
    input  logic        nib_valid,
    input  logic [3:0]  nib_data,
    output logic        nib_ready,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [31:0] word,
    output logic        busy
`ifdef WORD_PARITY_EN
    ,
    output logic        word_parity
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_acc;
    logic [2:0]  r_idx;
    logic        r_rev;

    logic        w_xfer;
    logic        w_last;
    logic [31:0] w_acc_next;

    assign nib_ready  = (r_state == ST_COLLECT) && !abort;
    assign w_xfer     = nib_valid && nib_ready;
    // The final nibble slot depends on direction; idx is never stepped past it.
    assign w_last     = r_rev ? (r_idx == 3'd0) : (r_idx == 3'd7);
    assign word       = r_acc;
    assign word_valid = (r_state == ST_HOLD);
    assign busy       = (r_state != ST_IDLE);

    always_comb begin
        w_acc_next = r_acc;
        w_acc_next[{r_idx, 2'b00} +: 4] = nib_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_acc   <= 32'd0;
            r_idx   <= 3'd0;
            r_rev   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_COLLECT;
                        r_acc   <= 32'd0;
                        r_rev   <= reverse_direction;
                        r_idx   <= reverse_direction ? 3'd7 : 3'd0;
                    end
                end
                ST_COLLECT: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                    end else if (w_xfer) begin
                        r_acc <= w_acc_next;
                        if (w_last) begin
                            r_state <= ST_HOLD;
                        end else begin
                            r_idx <= r_rev ? (r_idx - 3'd1) : (r_idx + 3'd1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (word_ready) begin
                        if (start) begin
                            r_state <= ST_COLLECT;
                            r_acc   <= 32'd0;
                            r_rev   <= reverse_direction;
                            r_idx   <= reverse_direction ? 3'd7 : 3'd0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef WORD_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (w_xfer && w_last) begin
            r_parity <= ^w_acc_next;
        end
    end

    assign word_parity = r_parity;
`endif

endmodule

// File: tb/tb_nibble_word_assembler.sv
// Self-checking bench for nibble_word_assembler: directed scenarios with literal words plus randomized traffic vs a reference model.
module tb_nibble_word_assembler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        reverse_direction = 1'b0;
    logic        abort = 1'b0;
    logic        nib_valid = 1'b0;
    logic [3:0]  nib_data = 4'd0;
    logic        word_ready = 1'b0;
    logic        nib_ready;
    logic        word_valid;
    logic [31:0] word;
    logic        busy;
`ifdef WORD_PARITY_EN
    logic        word_parity;
`endif

    always #5 clk = ~clk;

    nibble_word_assembler dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .reverse_direction (reverse_direction),
        .abort             (abort),
        .nib_valid         (nib_valid),
        .nib_data          (nib_data),
        .nib_ready         (nib_ready),
        .word_valid        (word_valid),
        .word_ready        (word_ready),
        .word              (word),
        .busy              (busy)
`ifdef WORD_PARITY_EN
        ,
        .word_parity       (word_parity)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: phase 0=idle, 1=collecting, 2=holding; m_cnt counts nibbles taken so far.
    int          m_phase = 0;
    int          m_cnt   = 0;
    bit          m_rev   = 1'b0;
    logic [31:0] m_acc   = 32'd0;
    bit          m_par   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_cnt = 0; m_rev = 1'b0; m_acc = 32'd0; m_par = 1'b0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_phase = 1; m_cnt = 0; m_acc = 32'd0; m_rev = reverse_direction;
                end
                1: if (abort) begin
                    m_phase = 0;
                end else if (nib_valid) begin
                    m_acc = m_acc | (32'(nib_data) << (4 * (m_rev ? 7 - m_cnt : m_cnt)));
                    m_cnt++;
                    if (m_cnt == 8) begin
                        m_phase = 2;
                        m_par   = ^m_acc;
                    end
                end
                default: if (word_ready) begin
                    if (start) begin
                        m_phase = 1; m_cnt = 0; m_acc = 32'd0; m_rev = reverse_direction;
                    end else begin
                        m_phase = 0;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        chk("nib_ready", 32'(nib_ready), 32'(m_phase == 1 && !abort));
        chk("word_valid", 32'(word_valid), 32'(m_phase == 2));
        chk("busy", 32'(busy), 32'(m_phase != 0));
        chk("word", word, m_acc);
`ifdef WORD_PARITY_EN
        if (m_phase == 2) chk("word_parity", 32'(word_parity), 32'(m_par));
`endif
    end

    task automatic cyc(input bit st, input bit rv, input bit ab, input bit nv,
                       input logic [3:0] nd, input bit wr);
        start = st; reverse_direction = rv; abort = ab;
        nib_valid = nv; nib_data = nd; word_ready = wr;
        @(posedge clk);
        #2;
    endtask

    logic [3:0] d1[8] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF};
    logic [3:0] d3[8] = '{4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h1};
    logic [3:0] d5[8] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1};

    initial begin
        repeat (2) @(posedge clk);
        #2;
        chk("rst_word", word, 32'd0);
        chk("rst_word_valid", 32'(word_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_nib_ready", 32'(nib_ready), 32'd0);
        rst_n = 1'b1;
        cyc(0, 0, 0, 1, 4'h3, 1);
        chk("idle_no_ready", 32'(nib_ready), 32'd0);

        // Forward word with a single-cycle hold
        cyc(1, 0, 0, 0, 4'h0, 1);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, d1[i], 1);
        chk("fwd_word", word, 32'hF000_FFFF);
        chk("fwd_valid", 32'(word_valid), 32'd1);
        cyc(0, 0, 0, 0, 4'h0, 1);
        chk("fwd_release_valid", 32'(word_valid), 32'd0);
        chk("fwd_release_busy", 32'(busy), 32'd0);

        // Reverse word
        cyc(1, 1, 0, 0, 4'h0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 4'(i + 1), 0);
        chk("rev_word", word, 32'h1234_5678);
`ifdef WORD_PARITY_EN
        chk("rev_parity", 32'(word_parity), 32'd1);
`endif
        cyc(0, 0, 0, 0, 4'h0, 1);

        // Backpressure on both sides
        cyc(1, 0, 0, 0, 4'h0, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0, 1, d3[i], 0);
            cyc(0, 0, 0, 0, 4'h5, 0);
        end
        for (int j = 0; j < 5; j++) begin
            chk("bp_word", word, 32'h1FED_CBA9);
            chk("bp_valid", 32'(word_valid), 32'd1);
            chk("bp_nib_ready", 32'(nib_ready), 32'd0);
            cyc(0, 0, 0, 1, 4'($urandom), 0);
        end
        cyc(0, 0, 0, 0, 4'h0, 1);

        // Abort after three nibbles, then a fresh word
        cyc(1, 0, 0, 0, 4'h0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 4'(i + 1), 0);
        cyc(0, 0, 1, 1, 4'h7, 0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(word_valid), 32'd0);
        cyc(1, 0, 0, 0, 4'h0, 0);
        chk("abort_clear", word, 32'd0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 4'(i + 1), 0);
        chk("abort_new_word", word, 32'h8765_4321);
        cyc(0, 0, 0, 0, 4'h0, 1);

        // Back-to-back words
        cyc(1, 0, 0, 0, 4'h0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 4'(i), 0);
        chk("b2b_first", word, 32'h7654_3210);
        cyc(1, 1, 0, 0, 4'h0, 1);
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_no_valid", 32'(word_valid), 32'd0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, d5[i], 1);
        chk("b2b_second", word, 32'hABCD_EF01);
        cyc(0, 0, 0, 0, 4'h0, 1);

        // Reset in the middle of a word
        cyc(1, 0, 0, 0, 4'h0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 4'hC, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_word", word, 32'd0);
        chk("midrst_valid", 32'(word_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_nib_ready", 32'(nib_ready), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 4'h3, 1);
            chk("post_rst_nib_ready", 32'(nib_ready), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
        end

        // Randomized traffic, checked every cycle against the model
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 4) == 0, 1'($urandom % 2), $urandom_range(0, 19) == 0,
                $urandom_range(0, 9) < 6, 4'($urandom), $urandom_range(0, 9) < 4);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
